// File: rtl/ldpc_pkg.sv
// Shared definitions for the 6-bit LDPC bit-flipping decoder.
// Holds the controller state enum, the default parity-check rows and a
// syndrome helper used by both the decoder and the encoder check path.
package ldpc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSynd,
    StCheck,
    StWait,
    StApply,
    StDone
  } state_e;

  // Default parity-check rows; row 1 drives syndrome bit 2, row 3 bit 0.
  localparam logic [5:0] H1_DEFAULT = 6'b110100;
  localparam logic [5:0] H2_DEFAULT = 6'b011010;
  localparam logic [5:0] H3_DEFAULT = 6'b101001;

  function automatic logic [2:0] ldpc_syndrome(input logic [5:0] cw, input logic [5:0] h1,
                                               input logic [5:0] h2, input logic [5:0] h3);
    logic [2:0] s;
    s[2] = ^(cw & h1);
    s[1] = ^(cw & h2);
    s[0] = ^(cw & h3);
    return s;
  endfunction

endpackage

// File: rtl/ldpc_bf_ctrl_if.sv
// Bundle of the ldpc_bf_ctrl data-path signals.
//   in_valid/in_ready/in_cw      : codeword input handshake
//   sy/c1/c2/c3/v                : syndrome and check rows to flipc, flip vector back
//   out_valid/out_ready/out_cw/
//   out_err/out_iter             : decoded result handshake and status
// Modports: master = upstream/downstream/flipc side, slave = the controller.
interface ldpc_bf_ctrl_if #(
  parameter int unsigned ITER_W = 3
);

  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_cw;
  logic [2:0]        sy;
  logic [5:0]        c1;
  logic [5:0]        c2;
  logic [5:0]        c3;
  logic [5:0]        v;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        out_cw;
  logic              out_err;
  logic [ITER_W-1:0] out_iter;

  modport master (
    output in_valid, in_cw, v, out_ready,
    input  in_ready, sy, c1, c2, c3, out_valid, out_cw, out_err, out_iter
  );

  modport slave (
    input  in_valid, in_cw, v, out_ready,
    output in_ready, sy, c1, c2, c3, out_valid, out_cw, out_err, out_iter
  );

endinterface

// File: rtl/ldpc_synd.sv
// Combinational syndrome and syndrome-weight calculator.
//   cw     : codeword under test
//   h1..h3 : parity-check rows (h1 -> s[2], h3 -> s[0])
//   s      : 3-bit syndrome
//   weight : number of set syndrome bits (0..3)
module ldpc_synd
  import ldpc_pkg::*;
(
  input  logic [5:0] cw,
  input  logic [5:0] h1,
  input  logic [5:0] h2,
  input  logic [5:0] h3,
  output logic [2:0] s,
  output logic [1:0] weight
);

  always_comb begin
    s      = ldpc_syndrome(cw, h1, h2, h3);
    weight = {1'b0, s[2]} + {1'b0, s[1]} + {1'b0, s[0]};
  end

endmodule

// File: rtl/ldpc_bf_ctrl.sv
// Iteration controller for the 6-bit LDPC bit-flipping decoder.
// Accepts a codeword, computes its syndrome, hands syndrome and check rows to
// the external flipc stage, applies the returned flip vector and repeats until
// the syndrome clears, becomes uncorrectable or the iteration budget runs out.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : ldpc_bf_ctrl_if.slave (input handshake, flipc link, result handshake)
// Build option:
//   LDPC_BF_FLIP_MASK_EN defined   -> flip mask = v & rows of both failing checks
//   LDPC_BF_FLIP_MASK_EN undefined -> flip mask = v
module ldpc_bf_ctrl
  import ldpc_pkg::*;
#(
  parameter logic [5:0]  H1       = H1_DEFAULT,
  parameter logic [5:0]  H2       = H2_DEFAULT,
  parameter logic [5:0]  H3       = H3_DEFAULT,
  parameter int unsigned MAX_ITER = 4,
  parameter int unsigned ITER_W   = 3
) (
  input logic            clk,
  input logic            rst,
  ldpc_bf_ctrl_if.slave  bus
);

  localparam logic [ITER_W-1:0] MaxIter = ITER_W'(MAX_ITER);

  state_e            state_q, state_d;
  logic [5:0]        cw_q;
  logic [ITER_W-1:0] iter_q;
  logic [2:0]        sy_q;
  logic [5:0]        out_cw_q;
  logic              out_err_q;
  logic [ITER_W-1:0] out_iter_q;

  logic [2:0] s;
  logic [1:0] weight;
  logic [5:0] mask;
  logic       load_cw;
  logic       load_sy;
  logic       apply;
  logic       finish;
  logic       err_d;

  ldpc_synd u_synd (
    .cw     (cw_q),
    .h1     (H1),
    .h2     (H2),
    .h3     (H3),
    .s      (s),
    .weight (weight)
  );

`ifdef LDPC_BF_FLIP_MASK_EN
  // Only reached with weight-2 syndromes, so exactly two rows are ANDed.
  logic [5:0] row_and;
  assign row_and = (sy_q[2] ? H1 : 6'h3f) & (sy_q[1] ? H2 : 6'h3f) & (sy_q[0] ? H3 : 6'h3f);
  assign mask    = bus.v & row_and;
`else
  assign mask = bus.v;
`endif

  always_comb begin
    state_d = state_q;
    load_cw = 1'b0;
    load_sy = 1'b0;
    apply   = 1'b0;
    finish  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          load_cw = 1'b1;
          state_d = StSynd;
        end
      end
      StSynd: begin
        load_sy = 1'b1;
        state_d = StCheck;
      end
      StCheck: begin
        // cw_q is unchanged since SYND, so weight matches the registered sy.
        if (weight == 2'd0) begin
          finish  = 1'b1;
          state_d = StDone;
        end else if (weight != 2'd2 || iter_q == MaxIter) begin
          finish  = 1'b1;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        state_d = StApply;
      end
      StApply: begin
        apply   = 1'b1;
        state_d = StSynd;
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cw_q       <= '0;
      iter_q     <= '0;
      sy_q       <= '0;
      out_cw_q   <= '0;
      out_err_q  <= 1'b0;
      out_iter_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_cw) begin
        cw_q   <= bus.in_cw;
        iter_q <= '0;
      end
      if (load_sy) begin
        sy_q <= s;
      end
      if (apply) begin
        cw_q <= cw_q ^ mask;
        if (iter_q < MaxIter) begin
          iter_q <= iter_q + 1'b1;
        end
      end
      if (finish) begin
        out_cw_q   <= cw_q;
        out_err_q  <= err_d;
        out_iter_q <= iter_q;
      end
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sy        = sy_q;
  assign bus.c1        = H1;
  assign bus.c2        = H2;
  assign bus.c3        = H3;
  assign bus.out_cw    = out_cw_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_iter  = out_iter_q;

endmodule

// File: tb/tb_ldpc_bf_ctrl.sv
// Directed, table-driven bench for ldpc_bf_ctrl with hand-computed expectations.
module tb_ldpc_bf_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ldpc_bf_ctrl_if #(.ITER_W(3)) bus ();

  ldpc_bf_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] cw;
    logic [5:0] v;
    logic [5:0] exp_cw;
    logic       exp_err;
    logic [2:0] exp_iter;
    logic [2:0] exp_sy;
    int         exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge where out_valid is seen.
  task automatic send_word(input logic [5:0] cw, input logic [5:0] v, output int lat);
    bus.in_cw    = cw;
    bus.v        = v;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid after handshake", 32'(bus.out_valid), 32'd0);
    check("in_ready after handshake", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    checks = 0;
    errors = 0;

    vecs[0] = '{6'b000000, 6'b000000, 6'b000000, 1'b0, 3'd0, 3'b000, 3};
`ifdef LDPC_BF_FLIP_MASK_EN
    vecs[1] = '{6'b010000, 6'b010001, 6'b000000, 1'b0, 3'd1, 3'b000, 7};
    vecs[2] = '{6'b100000, 6'b100010, 6'b000000, 1'b0, 3'd1, 3'b000, 7};
`else
    vecs[1] = '{6'b010000, 6'b010001, 6'b000001, 1'b1, 3'd1, 3'b001, 7};
    vecs[2] = '{6'b100000, 6'b100010, 6'b000010, 1'b1, 3'd1, 3'b010, 7};
`endif
    vecs[3] = '{6'b000001, 6'b111111, 6'b000001, 1'b1, 3'd0, 3'b001, 3};
    // Flipc never helps: budget of 4 iterations exhausted.
    vecs[4] = '{6'b010000, 6'b000000, 6'b010000, 1'b1, 3'd4, 3'b110, 19};
    vecs[5] = '{6'b111111, 6'b000000, 6'b111111, 1'b1, 3'd0, 3'b111, 3};
    vecs[6] = '{6'b100101, 6'b111111, 6'b100101, 1'b0, 3'd0, 3'b000, 3};
    vecs[7] = '{6'b110101, 6'b010000, 6'b100101, 1'b0, 3'd1, 3'b000, 7};

    bus.in_valid  = 1'b0;
    bus.in_cw     = '0;
    bus.v         = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_cw", 32'(bus.out_cw), 32'd0);
    check("reset out_err", 32'(bus.out_err), 32'd0);
    check("reset out_iter", 32'(bus.out_iter), 32'd0);
    check("reset sy", 32'(bus.sy), 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("c1", 32'(bus.c1), 32'h34);
    check("c2", 32'(bus.c2), 32'h1a);
    check("c3", 32'(bus.c3), 32'h29);

    for (int i = 0; i < 8; i++) begin
      check($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'd1);
      send_word(vecs[i].cw, vecs[i].v, lat);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d out_cw", i), 32'(bus.out_cw), 32'(vecs[i].exp_cw));
      check($sformatf("v%0d out_err", i), 32'(bus.out_err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d out_iter", i), 32'(bus.out_iter), 32'(vecs[i].exp_iter));
      check($sformatf("v%0d sy", i), 32'(bus.sy), 32'(vecs[i].exp_sy));
      release_result();
    end

    // Hold DONE with out_ready low; a competing in_valid must be ignored.
    send_word(6'b000001, 6'b000000, lat);
    check("hold latency", 32'(lat), 32'd3);
    bus.in_valid = 1'b1;
    bus.in_cw    = 6'b111111;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("hold%0d out_valid", k), 32'(bus.out_valid), 32'd1);
      check($sformatf("hold%0d in_ready", k), 32'(bus.in_ready), 32'd0);
      check($sformatf("hold%0d out_cw", k), 32'(bus.out_cw), 32'h01);
      check($sformatf("hold%0d out_err", k), 32'(bus.out_err), 32'd1);
    end
    bus.in_valid = 1'b0;
    release_result();

    // Reset while in WAIT discards the word.
    bus.in_cw    = 6'b010000;
    bus.v        = 6'b000000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre-reset sy in WAIT", 32'(bus.sy), 32'h6);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst-in-wait in_ready", 32'(bus.in_ready), 32'd1);
    check("rst-in-wait out_valid", 32'(bus.out_valid), 32'd0);
    check("rst-in-wait sy", 32'(bus.sy), 32'd0);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("rst-in-wait no out_valid", 32'(seen), 32'd0);

    send_word(vecs[7].cw, vecs[7].v, lat);
    check("post-reset latency", 32'(lat), 32'd7);
    check("post-reset out_cw", 32'(bus.out_cw), 32'h25);
    check("post-reset out_err", 32'(bus.out_err), 32'd0);
    check("post-reset out_iter", 32'(bus.out_iter), 32'd1);
    release_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
